// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle core: fetch, decode, execute,
// memory and write-back sequencing with bounded memory handshakes.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_we,
  output logic [2:0] imm_sel,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BR,
    C_LUI,
    C_JAL,
    C_JALR
  } cls_t;

  state_t        state;
  state_t        state_nx;
  cls_t          cls;
  cls_t          cls_nx;
  cls_t          dec_cls;
  logic          dec_ok;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    cause;
  logic [1:0]    cause_nx;
  logic          expired;
  logic [2:0]    ex_imm;
  logic          ex_asb;
  logic [1:0]    ex_aop;

  // Counter holds the number of wait cycles already spent this access.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_IALU;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BR;
      7'b0110111: dec_cls = C_LUI;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    ex_imm = 3'b111;
    ex_asb = 1'b0;
    ex_aop = 2'b00;
    unique case (cls)
      C_R: ex_aop = 2'b10;
      C_IALU, C_LOAD, C_JALR: begin
        ex_imm = 3'b000;
        ex_asb = 1'b1;
      end
      C_STORE: begin
        ex_imm = 3'b001;
        ex_asb = 1'b1;
      end
      C_BR: begin
        ex_imm = 3'b010;
        ex_aop = 2'b01;
      end
      C_LUI: ex_imm = 3'b011;
      C_JAL: ex_imm = 3'b100;
    endcase
  end

  always_comb begin
    state_nx = state;
    cls_nx   = cls;
    cause_nx = cause;
    unique case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_nx = S_DECODE;
        end else if (expired) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          cls_nx   = dec_cls;
          state_nx = S_EXEC;
        end else begin
          cause_nx = 2'b01;
          state_nx = S_TRAP;
        end
      end
      S_EXEC: begin
        if (cls == C_BR) begin
          state_nx = S_FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
        end else if (expired) begin
          state_nx = S_TRAP;
          cause_nx = 2'b11;
        end
      end
      S_WB:    state_nx = S_FETCH;
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
    // Any state change (entry, ack, trap) restarts the wait count.
    cnt_nx = '0;
    if ((state == S_FETCH || state == S_MEM) &&
        (state_nx == state)) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      cls   <= C_R;
      cnt   <= '0;
      cause <= 2'b00;
    end else begin
      state <= state_nx;
      cls   <= cls_nx;
      cnt   <= cnt_nx;
      cause <= cause_nx;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    imm_sel   = 3'b111;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    trap      = 1'b0;
    // Outputs are forced idle while reset is held, even mid-access.
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_DECODE: begin
        end
        S_EXEC: begin
          imm_sel   = ex_imm;
          alu_src_b = ex_asb;
          alu_op    = ex_aop;
          if (cls == C_BR) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          imm_sel   = ex_imm;
          alu_src_b = ex_asb;
          alu_op    = ex_aop;
          dmem_req  = 1'b1;
          dmem_we   = (cls == C_STORE);
          if (dmem_ack && cls == C_STORE) begin
            pc_we = 1'b1;
          end
        end
        S_WB: begin
          imm_sel   = ex_imm;
          alu_src_b = ex_asb;
          alu_op    = ex_aop;
          reg_we    = 1'b1;
          pc_we     = 1'b1;
          unique case (cls)
            C_LOAD:        wb_sel = 2'b01;
            C_JAL, C_JALR: wb_sel = 2'b10;
            C_LUI:         wb_sel = 2'b11;
            default:       wb_sel = 2'b00;
          endcase
          unique case (cls)
            C_JAL:   pc_src = 2'b01;
            C_JALR:  pc_src = 2'b10;
            default: pc_src = 2'b00;
          endcase
        end
        S_TRAP:  trap = 1'b1;
        default: begin
        end
      endcase
    end
  end

  assign retire     = pc_we;
  assign trap_cause = cause;

endmodule
